// File: rtl/limn2600_bus_fabric_if.sv
// Limn2600 system bus bundle: CPU-side request/response plus the broadcast
// slave-side signals. The slave modport is the fabric's view of the bus.
interface limn2600_bus_fabric_if #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
);
    logic                         m_cs;
    logic                         m_we;
    logic [ADDR_W-1:0]            m_addr;
    logic [DATA_W-1:0]            m_data_in;
    logic [DATA_W-1:0]            m_data_out;
    logic                         m_rdy;
    logic                         m_err;
    logic [NUM_SLAVES-1:0]        s_cs;
    logic                         s_we;
    logic [ADDR_W-1:0]            s_addr;
    logic [DATA_W-1:0]            s_data_out;
    logic [NUM_SLAVES*DATA_W-1:0] s_data_in;
    logic [NUM_SLAVES-1:0]        s_rdy;

    modport master (
        output m_cs, m_we, m_addr, m_data_in,
        input  m_data_out, m_rdy, m_err
    );

    modport slave (
        input  m_cs, m_we, m_addr, m_data_in, s_data_in, s_rdy,
        output m_data_out, m_rdy, m_err, s_cs, s_we, s_addr, s_data_out
    );
endinterface

// File: rtl/limn2600_bus_fabric.sv
// Single-master, multi-slave Limn2600 bus fabric: registers one CPU request,
// routes it to the address-decoded slave and returns data, or an error on unmapped/timeout.
module limn2600_bus_fabric #(
    parameter int                          NUM_SLAVES = 4,
    parameter int                          ADDR_W     = 32,
    parameter int                          DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
        {32'hF9000000, 32'hF8000000, 32'h10000000, 32'h00000000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK =
        {32'hFF000000, 32'hFF000000, 32'hF0000000, 32'hF0000000},
    parameter int                          TIMEOUT    = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    limn2600_bus_fabric_if.slave bus,
    output logic [1:0]           state_o
);
    // Handshake: master holds m_cs (and its address/data) until it sees the
    // one-cycle m_rdy pulse; the selected slave answers with s_rdy while its s_cs is high.
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [NUM_SLAVES-1:0] s_cs_q, s_cs_d;
    logic                  s_we_q, s_we_d;
    logic [ADDR_W-1:0]     s_addr_q, s_addr_d;
    logic [DATA_W-1:0]     s_wdata_q, s_wdata_d;
    logic                  m_rdy_q, m_rdy_d;
    logic                  m_err_q, m_err_d;
    logic [DATA_W-1:0]     m_rdata_q, m_rdata_d;

    logic                  dec_hit;
    logic [SEL_W-1:0]      dec_sel;
    logic                  sel_rdy;
    logic [DATA_W-1:0]     sel_rdata;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        dec_hit = 1'b0;
        dec_sel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((bus.m_addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
                dec_hit = 1'b1;
                dec_sel = SEL_W'(i);
            end
        end
    end

    always_comb begin
        sel_rdy   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_rdy   = bus.s_rdy[i];
                sel_rdata = bus.s_data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        s_cs_d    = s_cs_q;
        s_we_d    = s_we_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        m_rdy_d   = 1'b0;
        m_err_d   = m_err_q;
        m_rdata_d = m_rdata_q;
        case (state_q)
            IDLE: begin
                m_err_d = 1'b0;
                s_cs_d  = '0;
                if (bus.m_cs) begin
                    s_addr_d  = bus.m_addr;
                    s_we_d    = bus.m_we;
                    s_wdata_d = bus.m_data_in;
                    if (dec_hit) begin
                        state_d = ACCESS;
                        sel_d   = dec_sel;
                        cnt_d   = '0;
                        for (int i = 0; i < NUM_SLAVES; i++) begin
                            s_cs_d[i] = (dec_sel == SEL_W'(i));
                        end
                    end else begin
                        state_d   = RESP;
                        m_rdy_d   = 1'b1;
                        m_err_d   = 1'b1;
                        m_rdata_d = '1;
                    end
                end
            end
            ACCESS: begin
                if (sel_rdy) begin
                    state_d = RESP;
                    s_cs_d  = '0;
                    m_rdy_d = 1'b1;
                    m_err_d = 1'b0;
                    if (!s_we_q) begin
                        m_rdata_d = sel_rdata;
                    end
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    state_d   = RESP;
                    s_cs_d    = '0;
                    m_rdy_d   = 1'b1;
                    m_err_d   = 1'b1;
                    m_rdata_d = '1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                m_err_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                s_cs_d  = '0;
                m_err_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sel_q     <= '0;
            s_cs_q    <= '0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            m_rdy_q   <= 1'b0;
            m_err_q   <= 1'b0;
            m_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            s_cs_q    <= s_cs_d;
            s_we_q    <= s_we_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            m_rdy_q   <= m_rdy_d;
            m_err_q   <= m_err_d;
            m_rdata_q <= m_rdata_d;
        end
    end

    assign bus.s_cs       = s_cs_q;
    assign bus.s_we       = s_we_q;
    assign bus.s_addr     = s_addr_q;
    assign bus.s_data_out = s_wdata_q;
    assign bus.m_rdy      = m_rdy_q;
    assign bus.m_err      = m_err_q;
    assign bus.m_data_out = m_rdata_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_limn2600_bus_fabric.sv
// Bench for limn2600_bus_fabric: directed scenarios plus randomized traffic,
// checked cycle by cycle against a transaction-level model of the fabric.
module tb_limn2600_bus_fabric;
    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam logic [NS*AW-1:0] BASE = {32'hF8000000, 32'hF8000000, 32'h10000000, 32'h00000000};
    localparam logic [NS*AW-1:0] MASK = {32'hFFFF0000, 32'hFF000000, 32'hF0000000, 32'hF0000000};

    logic [AW-1:0] base_a [NS] = '{32'h00000000, 32'h10000000, 32'hF8000000, 32'hF8000000};
    logic [AW-1:0] mask_a [NS] = '{32'hF0000000, 32'hF0000000, 32'hFF000000, 32'hFFFF0000};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] state;

    always #5 clk = ~clk;

    limn2600_bus_fabric_if #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

    limn2600_bus_fabric #(
        .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
        .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT(TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state)
    );

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW:0]   exp_q [$];
    logic [DW-1:0] last_rdata = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int decode(input logic [AW-1:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & mask_a[i]) == base_a[i]) return i;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_slaves_random(input bit stray_all);
        for (int i = 0; i < NS; i++) begin
            bus.s_data_in[i*DW +: DW] = $urandom;
        end
        bus.s_rdy = stray_all ? '1 : NS'($urandom);
    endtask

    // One full transaction; k counts clock edges after the request edge.
    task automatic txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input int waits, input logic [DW-1:0] rdata, input bit stray_all);
        int          sel;
        int          hold;
        logic [DW:0] e;
        logic [NS-1:0] cs_exp;
        sel = decode(addr);
        if (sel < 0) begin
            hold = 0;
            exp_q.push_back({1'b1, {DW{1'b1}}});
        end else if (waits + 1 > TO) begin
            hold = TO;
            exp_q.push_back({1'b1, {DW{1'b1}}});
        end else begin
            hold = waits + 1;
        end
        bus.m_cs      = 1'b1;
        bus.m_we      = we;
        bus.m_addr    = addr;
        bus.m_data_in = wdata;
        for (int k = 0; k <= hold + 1; k++) begin
            step();
            cs_exp = (sel >= 0 && k < hold) ? NS'(1 << sel) : '0;
            check("s_cs", bus.s_cs, cs_exp);
            if (k < hold) begin
                check("s_addr", bus.s_addr, addr);
                check("s_we", bus.s_we, we);
                check("s_data_out", bus.s_data_out, wdata);
            end
            check("m_rdy", bus.m_rdy, (k == hold));
            if (k == hold) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL resp_queue: got response with no expectation at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("m_err", bus.m_err, e[DW]);
                    check("m_data_out", bus.m_data_out, e[DW-1:0]);
                    last_rdata = e[DW-1:0];
                end
                bus.m_cs = 1'b0;
            end else if (k == hold + 1) begin
                check("m_err_clear", bus.m_err, 1'b0);
                check("m_data_hold", bus.m_data_out, last_rdata);
            end
            drive_slaves_random(stray_all);
            if (sel >= 0) begin
                bus.s_rdy[sel] = (k < hold && k == waits);
                if (k < hold) bus.s_data_in[sel*DW +: DW] = rdata;
                if (k < hold && k == waits) exp_q.push_back({1'b0, we ? last_rdata : rdata});
            end
        end
        bus.s_rdy = '0;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL resp_missing: %0d expected responses never seen", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_s_cs"}, bus.s_cs, '0);
        check({tag, "_s_we"}, bus.s_we, 1'b0);
        check({tag, "_s_addr"}, bus.s_addr, '0);
        check({tag, "_s_data_out"}, bus.s_data_out, '0);
        check({tag, "_m_rdy"}, bus.m_rdy, 1'b0);
        check({tag, "_m_err"}, bus.m_err, 1'b0);
        check({tag, "_m_data_out"}, bus.m_data_out, '0);
    endtask

    initial begin
        logic [AW-1:0] a;
        int            kind;
        bus.m_cs      = 1'b0;
        bus.m_we      = 1'b0;
        bus.m_addr    = '0;
        bus.m_data_in = '0;
        bus.s_data_in = '0;
        bus.s_rdy     = '0;
        repeat (3) step();
        check_quiet("reset");
        rst = 1'b1;
        step();

        txn(1'b0, 32'h00000040, 32'h0, 0, 32'hDEADBEEF, 1'b0);
        txn(1'b1, 32'hF8000010, 32'hCAFEF00D, 3, 32'h12345678, 1'b0);
        txn(1'b0, 32'h20000000, 32'h0, 0, 32'h0, 1'b0);
        txn(1'b0, 32'h10000100, 32'h0, 1000, 32'h0, 1'b0);
        txn(1'b0, 32'h10000104, 32'h0, TO - 1, 32'hA5A5A5A5, 1'b0);
        txn(1'b0, 32'hF8000004, 32'h0, 2, 32'h0BADF00D, 1'b1);
        txn(1'b1, 32'h00001000, 32'h55AA55AA, 0, 32'h0, 1'b0);

        // Abort in the second ACCESS cycle.
        bus.m_cs   = 1'b1;
        bus.m_we   = 1'b0;
        bus.m_addr = 32'h10000004;
        step();
        check("abort_s_cs0", bus.s_cs, 4'b0010);
        step();
        check("abort_s_cs1", bus.s_cs, 4'b0010);
        rst = 1'b0;
        step();
        check_quiet("abort");
        bus.m_cs = 1'b0;
        step();
        check("abort_m_rdy", bus.m_rdy, 1'b0);
        rst = 1'b1;
        last_rdata = '0;
        txn(1'b0, 32'h10000008, 32'h0, 1, 32'h600DCAFE, 1'b0);

        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0: a = {4'h0, 28'($urandom)};
                1: a = {4'h1, 28'($urandom)};
                2: a = {8'hF8, 24'($urandom)};
                3: a = {8'hF8, 8'h00, 16'($urandom)};
                4: a = {4'($urandom_range(2, 7)), 28'($urandom)};
                default: a = {8'hF9, 24'($urandom)};
            endcase
            txn(1'($urandom), a, $urandom, $urandom_range(0, 9), $urandom, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/limn2600_bus_fabric.md
Name: limn2600_bus_fabric

Overview:
Single-master, multi-slave system bus interconnect for Limn2600 SoCs. It generalises the direct CPU-to-SRAM hookup to NUM_SLAVES address-decoded targets (RAM, ROM, MMIO). It registers each CPU request, routes it to the matching slave, and waits for that slave's rdy. It returns data or a bus error, with a watchdog timeout for slaves that never answer.

Parameters:
NUM_SLAVES, 4, number of slave ports
ADDR_W, 32, address width
DATA_W, 32, data width
SLAVE_BASE, {32'hF9000000,32'hF8000000,32'h10000000,32'h00000000}, packed NUM_SLAVES*ADDR_W base addresses; slave 0 in the LSBs
SLAVE_MASK, {32'hFF000000,32'hFF000000,32'hF0000000,32'hF0000000}, packed NUM_SLAVES*ADDR_W decode masks
TIMEOUT, 256, maximum ACCESS cycles before bus error; 0 disables the timeout

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset, synchronous, active-low
m_cs  in  1  master request
m_we  in  1  master write enable (1=write)
m_addr  in  ADDR_W  master address
m_data_in  in  DATA_W  master write data
m_data_out  out  DATA_W  read data to master
m_rdy  out  1  one-cycle completion pulse
m_err  out  1  bus error, valid with m_rdy
s_cs  out  NUM_SLAVES  one-hot slave select
s_we  out  1  write enable, broadcast to all slaves
s_addr  out  ADDR_W  latched address, broadcast to all slaves
s_data_out  out  DATA_W  latched write data, broadcast to all slaves
s_data_in  in  NUM_SLAVES*DATA_W  packed slave read data; slave i at [i*DATA_W +: DATA_W]
s_rdy  in  NUM_SLAVES  per-slave ready

Behaviour:
- State machine: IDLE, ACCESS, RESP. All outputs are registered.
- Reset (rst==0 at an edge):
  - State goes to IDLE and the timeout counter goes to 0.
  - s_cs, s_we, s_addr, s_data_out, m_rdy, m_err and m_data_out all go to 0.
  - Reset during ACCESS aborts the transaction: s_cs drops at that edge and no m_rdy is issued.
- Address decode: slave i matches when (m_addr & MASK_i) == BASE_i.
  - When several slaves match, the lowest index wins.
  - When no slave matches, the access is unmapped.
- IDLE, m_cs==1 at an edge:
  - Latch m_addr, m_we and m_data_in into s_addr, s_we and s_data_out.
  - Mapped: go to ACCESS with s_cs = one-hot(sel) and counter = 0.
  - Unmapped: go to RESP with m_err=1 and m_data_out = all ones.
  - m_cs==0: stay in IDLE, s_cs=0.
- ACCESS:
  - s_cs, s_addr, s_we and s_data_out are held stable.
  - s_rdy[sel]==1 at an edge: s_cs goes to 0 and state goes to RESP with m_err=0.
  - On a read, m_data_out takes s_data_in[sel]. On a write, m_data_out keeps its previous value.
  - s_rdy from unselected slaves is ignored.
  - Otherwise the counter increments each cycle.
  - When counter == TIMEOUT-1 and TIMEOUT != 0: s_cs goes to 0, state goes to RESP, m_err=1, m_data_out = all ones.
  - If rdy and timeout occur in the same cycle, rdy wins and there is no error.
- RESP:
  - m_rdy=1 for exactly one cycle, then IDLE. m_rdy and m_err both go to 0 on leaving RESP.
  - m_data_out holds its value until the next response.
- m_cs is ignored in ACCESS and RESP; the master must hold its request until it sees m_rdy.
  - m_cs high in the IDLE cycle after RESP starts a new transaction.
- Latency:
  - Unmapped access: m_rdy is high 1 cycle after the request edge.
  - Mapped access with a zero-wait slave (rdy in the first s_cs cycle): m_rdy is high 2 cycles after the request edge.
  - Each slave wait cycle adds 1.
- Throughput: at most one transaction in flight, no pipelining.
- Back-to-back requests: sustained throughput is one transaction every 3 cycles with zero-wait slaves.

Test Plan:
1. Read of 0x00000040 with slave 0 zero-wait returning 0xDEADBEEF:
   - s_cs=4'b0001 one cycle after the request edge.
   - m_rdy pulses 2 cycles after the request edge with m_data_out=0xDEADBEEF, m_err=0.
2. Write of 0xCAFEF00D to 0xF8000010:
   - s_cs=4'b0100, s_we=1, s_data_out=0xCAFEF00D.
   - s_addr stays stable for 3 slave wait cycles.
   - m_rdy pulses 5 cycles after the request edge with m_err=0.
3. Access to unmapped 0x20000000:
   - No s_cs asserted.
   - m_rdy pulses 1 cycle after the request edge with m_err=1 and m_data_out=0xFFFFFFFF.
4. Slave 1 never asserts rdy, TIMEOUT=8:
   - s_cs stays high for 8 cycles, then drops.
   - m_rdy pulses with m_err=1.
   - Repeat with rdy arriving exactly in the 8th cycle: m_err=0.
5. Overlap override (SLAVE_BASE3=0xF8000000, MASK3=0xFFFF0000), access to 0xF8000004:
   - Only s_cs[2] is asserted.
   - Stray s_rdy[3]=1 during the access does not complete it.
6. rst driven low during the 2nd cycle of ACCESS:
   - s_cs=0 and m_rdy=0 from that edge on, state IDLE.
   - The next request after rst goes high completes normally.
